// File: rtl/gen2_timer_pkg.sv
// Shared types and constants for the Gen2 timer scheduler.
// State encoding, counter width and default saturation ceiling.
package gen2_timer_pkg;

    localparam int unsigned CNT_W         = 16;
    localparam int unsigned DEF_MAX_COUNT = 5000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_REL  = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] clamp_limit(input logic [CNT_W-1:0] lim,
                                                     input logic [CNT_W-1:0] ceil);
        return (lim > ceil) ? ceil : lim;
    endfunction

endpackage

// File: rtl/gen2_timer_sched_timer_core.sv
// Shared 16-bit timeout counter: clear/capture, qualified increment, limit compare.
// TIMER_SCHED_PRESCALE_EN adds a free-running prescaler that gates increments.
module timer_core
    import gen2_timer_pkg::*;
#(
    parameter int unsigned MAX_COUNT = DEF_MAX_COUNT
`ifdef TIMER_SCHED_PRESCALE_EN
    , parameter int unsigned PRESCALE_LOG2 = 2
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step_en,
    input  logic             tick_en,
    input  logic [CNT_W-1:0] lim_in,
    output logic [CNT_W-1:0] count,
    output logic             at_limit,
    output logic             saturated
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] lim;
    logic             tick_q;

`ifdef TIMER_SCHED_PRESCALE_EN
    logic [PRESCALE_LOG2-1:0] pre;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     pre <= '0;
        else if (clear) pre <= '0;
        else            pre <= pre + 1'b1;
    end

    assign tick_q = tick_en && (&pre);
`else
    assign tick_q = tick_en;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            lim   <= '0;
        end else if (clear) begin
            count <= '0;
            lim   <= clamp_limit(lim_in, MAX_C);
        end else if (step_en && tick_q && (count < MAX_C)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit  = (count >= lim);
    assign saturated = (count >= MAX_C);

endmodule

// File: rtl/gen2_timer_sched.sv
// Round-robin arbiter granting one shared timeout counter to NREQ requesters.
// Optional prescaler under TIMER_SCHED_PRESCALE_EN (see timer_core).
module gen2_timer_sched
    import gen2_timer_pkg::*;
#(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned MAX_COUNT = DEF_MAX_COUNT
`ifdef TIMER_SCHED_PRESCALE_EN
    , parameter int unsigned PRESCALE_LOG2 = 2
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick_en,
    input  logic [NREQ-1:0]       req,
    input  logic [CNT_W*NREQ-1:0] limit_flat,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [CNT_W-1:0]      count,
    output logic                  saturated
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state, nxt;
    logic [IDX_W-1:0] owner, sel;
    logic [NREQ-1:0]  sel_onehot;
    logic [CNT_W-1:0] owner_lim;
    logic             owner_req, at_limit, step_en, load;

    // owner doubles as the round-robin pointer; the nearest requester after it wins
    always_comb begin
        sel = owner;
        for (int unsigned i = NREQ; i >= 1; i--) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (req[j] && (((32'(owner) + i) % NREQ) == j)) sel = IDX_W'(j);
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        owner_lim  = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            sel_onehot[j] = (sel == IDX_W'(j));
            if (owner == IDX_W'(j)) owner_lim = limit_flat[j*CNT_W +: CNT_W];
        end
    end

    assign owner_req = |(req & grant);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            owner <= '0;
            grant <= '0;
        end else begin
            state <= nxt;
            if ((state == ST_IDLE) && (|req)) begin
                owner <= sel;
                grant <= sel_onehot;
            end else if (nxt == ST_IDLE) begin
                grant <= '0;
            end
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: if (|req) nxt = ST_LOAD;
            ST_LOAD: nxt = ST_RUN;
            ST_RUN: begin
                if (!owner_req)    nxt = ST_IDLE;
                else if (at_limit) nxt = ST_DONE;
            end
            ST_DONE: nxt = ST_REL;
            ST_REL:  if (!owner_req) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        done    = (state == ST_DONE) ? grant : '0;
        load    = (state == ST_LOAD);
        step_en = (state == ST_RUN) && owner_req && !at_limit;
    end

    timer_core #(
        .MAX_COUNT(MAX_COUNT)
`ifdef TIMER_SCHED_PRESCALE_EN
        , .PRESCALE_LOG2(PRESCALE_LOG2)
`endif
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .clear    (load),
        .step_en  (step_en),
        .tick_en  (tick_en),
        .lim_in   (owner_lim),
        .count    (count),
        .at_limit (at_limit),
        .saturated(saturated)
    );

endmodule

// File: tb/tb_gen2_timer_sched.sv
// Scoreboard bench for gen2_timer_sched: expected done pulses are queued by
// the stimulus and matched by a negedge monitor; state checks are direct.
module tb_gen2_timer_sched;

`ifdef TIMER_SCHED_PRESCALE_EN
    localparam int TPL = 4;
`else
    localparam int TPL = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_en;
    logic [2:0]  req;
    logic [47:0] limit_flat;
    logic [2:0]  grant, done;
    logic        busy, saturated;
    logic [15:0] count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int who;
        int at;
        int cnt;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    gen2_timer_sched #(.NREQ(3), .MAX_COUNT(5000)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_en   (tick_en),
        .req       (req),
        .limit_flat(limit_flat),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .count     (count),
        .saturated (saturated)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int who, input int at, input int cnt);
        exp_t e;
        e.who = who;
        e.at  = at;
        e.cnt = cnt;
        sbq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) tick(1);
    endtask

    always @(negedge clk) begin
        if (reset && (done != 3'b000)) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=%b want=none (edge %0d)", done, cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("done_owner", done, mon_e.who);
                check("done_edge", cyc, mon_e.at);
                check("done_count", count, mon_e.cnt);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, g, d, r;
        reset      = 1'b0;
        tick_en    = 1'b1;
        req        = 3'b000;
        limit_flat = '0;
        #2;
        check("rst_count", count, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", saturated, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(1);
        check("idle_busy", busy, 0);

        // single request, limit 10; limit change after capture is ignored
        k = cyc;
        req = 3'b001;
        limit_flat[15:0] = 16'd10;
        push_exp(1, k + 3 + 10*TPL, 10);
        tick(1);
        check("t1_grant", grant, 1);
        check("t1_busy", busy, 1);
        tick(1);
        limit_flat[15:0] = 16'd3;
        step_to(k + 3 + 10*TPL);
        tick(1);
        check("t1_rel_count", count, 10);
        check("t1_rel_grant", grant, 1);
        req = 3'b000;
        tick(1);
        check("t1_release", grant, 0);
        check("t1_idle", busy, 0);

        // limit 0
        k = cyc;
        req = 3'b010;
        limit_flat[31:16] = 16'd0;
        push_exp(2, k + 3, 0);
        tick(1);
        check("l0_grant", grant, 2);
        step_to(k + 3);
        tick(1);
        req = 3'b000;
        tick(1);

        // clamp to MAX_COUNT
        k = cyc;
        req = 3'b010;
        limit_flat[31:16] = 16'd60000;
        push_exp(2, k + 3 + 5000*TPL, 5000);
        tick(1);
        check("clamp_grant", grant, 2);
        step_to(k + 1 + 5000*TPL);
        check("pre_sat_count", count, 4999);
        check("pre_sat_flag", saturated, 0);
        tick(1);
        check("sat_count", count, 5000);
        check("sat_flag", saturated, 1);
        tick(1);
        tick(1);
        req = 3'b000;
        tick(1);

        // abort at count 40 with requester 2 pending
        k = cyc;
        req = 3'b001;
        limit_flat[15:0] = 16'd100;
        tick(1);
        check("ab_grant0", grant, 1);
        step_to(k + 5);
        req = 3'b101;
        limit_flat[47:32] = 16'd2;
        step_to(k + 2 + 40*TPL);
        check("ab_count", count, 40);
        req = 3'b100;
        tick(1);
        check("ab_grant_clr", grant, 0);
        check("ab_idle", busy, 0);
        tick(1);
        g = cyc;
        check("ab_grant2", grant, 4);
        push_exp(4, g + 2 + 2*TPL, 2);
        step_to(g + 2 + 2*TPL);
        tick(1);
        req = 3'b000;
        tick(1);

        // three simultaneous requests, round-robin from last owner 2
        limit_flat = {16'd2, 16'd2, 16'd2};
        k = cyc;
        req = 3'b111;
        tick(1);
        g = cyc;
        check("rr_grant0", grant, 1);
        d = g + 2 + 2*TPL;
        push_exp(1, d, 2);
        step_to(d);
        req = 3'b110;
        g = d + 3;
        d = g + 2 + 2*TPL;
        push_exp(2, d, 2);
        step_to(g);
        check("rr_grant1", grant, 2);
        step_to(d);
        req = 3'b100;
        g = d + 3;
        d = g + 2 + 2*TPL;
        push_exp(4, d, 2);
        step_to(g);
        check("rr_grant2", grant, 4);
        step_to(d);
        req = 3'b000;
        tick(2);
        check("rr_idle", grant, 0);

        // tick_en alternating, limit 4
`ifdef TIMER_SCHED_PRESCALE_EN
        r = 19;
`else
        r = 11;
`endif
        k = cyc;
        req = 3'b001;
        limit_flat[15:0] = 16'd4;
        push_exp(1, k + r, 4);
        while (cyc < k + r) begin
            tick_en = (((cyc + 1 - k) % 2) == 0);
            tick(1);
            if (cyc == k + 5) begin
`ifdef TIMER_SCHED_PRESCALE_EN
                check("tog_mid_count", count, 0);
`else
                check("tog_mid_count", count, 1);
`endif
            end
        end
        tick_en = 1'b1;
        tick(1);
        req = 3'b000;
        tick(1);

        // asynchronous reset mid-run at count 7
        k = cyc;
        req = 3'b001;
        limit_flat[15:0] = 16'd20;
        step_to(k + 2 + 7*TPL);
        check("ar_count_pre", count, 7);
        #2;
        reset = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_grant", grant, 0);
        check("ar_busy", busy, 0);
        check("ar_done", done, 0);
        #2;
        reset = 1'b1;
        tick(1);
        g = cyc;
        check("ar_regrant", grant, 1);
        push_exp(1, g + 2 + 20*TPL, 20);
        step_to(g + 2 + 20*TPL);
        tick(1);
        req = 3'b000;
        tick(2);

        check("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gen2_timer_sched.md
Name: gen2_timer_sched

Overview:
- Arbitrates one shared 16-bit saturating timeout counter among NREQ tag-side requesters: Gen2 T1 reply delay, RX command watchdog, and power-up settle.
- Each requester asks for a timed interval with its own limit. The block grants the counter round-robin, runs it, and pulses done to the owner.
- Sits between the tag FSM blocks and the timing datapath; the counter is held inside this block.

Parameters:
- NREQ, 3, number of requesters (2..8).
- MAX_COUNT, 5000, hard saturation ceiling; requested limits above it are clamped.
- PRESCALE_LOG2, 2, prescaler width when TIMER_SCHED_PRESCALE_EN is defined (tick every 2^PRESCALE_LOG2 clks).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick_en  in  1  count-enable qualifier; counter advances only when high.
- req  in  NREQ  per-requester timer request, level, held until release.
- limit_flat  in  16*NREQ  per-requester limit; requester i uses bits [16i+15:16i].
- grant  out  NREQ  one-hot current owner; all zero when idle.
- done  out  NREQ  one-cycle pulse to the owner when its interval expires.
- busy  out  1  high in any state other than IDLE.
- count  out  16  live counter value.
- saturated  out  1  count has reached MAX_COUNT.

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, grant=0, done=0, busy=0, saturated=0, rr pointer=0, captured limit=0.
- States: IDLE, LOAD, RUN, DONE, REL.
- IDLE:
  - If any req is high, select the first requester at or after (last_grant+1) mod NREQ.
  - Register grant one-hot; go to LOAD.
  - No req: stay in IDLE.
- LOAD, one cycle:
  - count<=0.
  - Capture lim = min(limit_flat[owner], MAX_COUNT).
  - Go to RUN.
- RUN:
  - If req[owner]=0 (abort): go to IDLE. grant clears, no done, rr pointer still updated to owner.
  - Else if count>=lim: go to DONE.
  - Else if tick_en (or prescaled tick): count<=count+1.
- DONE, one cycle:
  - done[owner]=1 (registered decode of state).
  - Go to REL.
- REL:
  - Hold grant and count until req[owner]=0, then go to IDLE and clear grant.
  - A requester must drop req for at least one cycle between intervals.
- Latency, tick_en=1 constantly, limit=L:
  - req sampled at edge 0; LOAD after edge 1; RUN from edge 2 with count=0.
  - count=L after edge L+2; done high in the cycle after edge L+3.
- Limit edge cases:
  - L=0: done after exactly 3 edges.
  - L>MAX_COUNT: treated as MAX_COUNT.
- Counter arithmetic: 16-bit unsigned, never wraps; saturated = (count>=MAX_COUNT).
- Simultaneous requests: round-robin; a newly arriving req never preempts the current owner.
- A req dropped and re-raised within REL by a non-owner is simply pending.
- limit_flat changes after LOAD are ignored for the current interval.

Optional Feature:
- Macro TIMER_SCHED_PRESCALE_EN.
- Defined:
  - A PRESCALE_LOG2-bit free-running prescaler, cleared in LOAD, gates increments.
  - count advances only when tick_en=1 and the prescaler is all-ones.
  - L ticks therefore cost L*2^PRESCALE_LOG2 clocks.
- Undefined: no prescaler; tick_en alone gates increments.

Decomposition:
- Package gen2_timer_pkg:
  - state enum encoding (IDLE=0, LOAD=1, RUN=2, DONE=3, REL=4, 3 bits).
  - CNT_W=16.
  - default MAX_COUNT constant 5000.
- One sub-module timer_core: the 16-bit counter with clear, enable, limit compare and saturation flag. It gets the same clk and async active-low reset.

Test Plan:
- req=001, limit0=10, tick_en=1 -> grant=001 after edge 1; done[0] pulses one cycle after edge 13; count holds 10 in REL; grant=0 one edge after req[0] drops.
- req=111 raised together, all limits 2 -> grants in order 001, 010, 100, each done after 5 edges; release each req on its done.
- req=010, limit1=60000 -> lim clamps to 5000; saturated=1 when count=5000; done follows on the next edge.
- Abort: req=001, limit0=100, drop req[0] at count=40 -> IDLE next edge, done never pulses; a pending req=100 is then granted.
- tick_en toggling 1,0,1,0 with limit=4 -> count increments only on tick_en=1 cycles; done 11 edges after req; with TIMER_SCHED_PRESCALE_EN (PRESCALE_LOG2=2) and tick_en=1, limit=3 -> done after about 3+12 edges.
- reset pulled low mid-RUN at count=7 -> count=0, grant=0, busy=0 immediately without waiting for clk; held req is regranted after release.
